// File: rtl/alif_pkg.sv
// rtl/alif_pkg.sv - shared types and defaults for the ALIF TDM scheduler
package alif_pkg;

  localparam int DEF_THRESHOLD  = 200;
  localparam int DEF_ADAPT_STEP = 40;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CALC  = 3'd2,
    S_WRITE = 3'd3,
    S_EMIT  = 3'd4
  } alif_state_e;

  typedef struct packed {
    logic [7:0] v_mem;
    logic [7:0] adapt;
  } neuron_state_t;

endpackage

// File: rtl/alif_update.sv
// rtl/alif_update.sv - combinational ALIF neuron update (v, a, I, leaks -> v', a', fire)
module alif_update
  import alif_pkg::*;
#(
  parameter int THRESHOLD  = DEF_THRESHOLD,
  parameter int ADAPT_STEP = DEF_ADAPT_STEP
) (
  input  logic [7:0] v,
  input  logic [7:0] a,
  input  logic [7:0] i_cur,
  input  logic [3:0] vm_leak,
  input  logic [3:0] ad_leak,
  output logic [7:0] next_v,
  output logic [7:0] next_a,
  output logic       fire
);

  localparam logic [7:0] THR   = 8'(THRESHOLD);
  localparam logic [7:0] STEP  = 8'(ADAPT_STEP);
  localparam logic [7:0] A_LIM = 8'(255 - ADAPT_STEP);

  logic [8:0] sum;
  logic [8:0] sub;
  logic [8:0] diff;

  // Fire resets v and bumps adaptation; otherwise integrate, leak and decay with floor/ceiling clamps
  always_comb begin
    sum    = {1'b0, v} + {1'b0, i_cur};
    sub    = {5'b0, vm_leak} + {3'b0, a[7:2]};
    diff   = sum - sub;
    fire   = (v >= THR);
    next_v = 8'h00;
    next_a = 8'h00;
    if (fire) begin
      next_v = 8'h00;
      next_a = (a < A_LIM) ? a + STEP : 8'hFF;
    end else begin
      if (sum > sub) next_v = (diff > 9'd255) ? 8'hFF : diff[7:0];
      next_a = (a > {4'b0, ad_leak}) ? a - {4'b0, ad_leak} : 8'h00;
    end
  end

endmodule

// File: rtl/alif_tdm_scheduler.sv
// rtl/alif_tdm_scheduler.sv - time-multiplexed ALIF scheduler; optional REFRACTORY_EN adds per-neuron refractory countdown
module alif_tdm_scheduler
  import alif_pkg::*;
#(
  parameter int N_NEURONS     = 8,
  parameter int THRESHOLD     = DEF_THRESHOLD,
  parameter int ADAPT_STEP    = DEF_ADAPT_STEP,
  parameter int REFRACT_TICKS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic                         cfg_we,
  input  logic [$clog2(N_NEURONS)-1:0] cfg_addr,
  input  logic [7:0]                   cfg_data,
  input  logic [3:0]                   vm_leak,
  input  logic [3:0]                   ad_leak,
  output logic                         spk_valid,
  output logic [$clog2(N_NEURONS)-1:0] spk_id,
  input  logic                         spk_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun,
  output logic [7:0]                   mon_vmem
);

  localparam int IW = $clog2(N_NEURONS);
  localparam logic [IW-1:0] LAST = IW'(N_NEURONS - 1);

  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_READ  = S_READ;
  localparam logic [2:0] ST_CALC  = S_CALC;
  localparam logic [2:0] ST_WRITE = S_WRITE;
  localparam logic [2:0] ST_EMIT  = S_EMIT;

  logic [2:0]    state;
  logic [IW-1:0] idx;
  neuron_state_t st_mem [N_NEURONS];
  logic [7:0]    cur_mem [N_NEURONS];

  logic [7:0] lat_v, lat_a, lat_i;
  logic [7:0] res_v, res_a;
  logic       res_fire;
  logic [7:0] upd_v, upd_a;
  logic       upd_fire;

`ifdef REFRACTORY_EN
  localparam logic [7:0] REFRACT_LOAD = 8'(REFRACT_TICKS);
  logic [7:0] refr [N_NEURONS];
`else
  logic unused_refract;
  assign unused_refract = |8'(REFRACT_TICKS);
`endif

  assign spk_id   = idx;
  assign mon_vmem = st_mem[0].v_mem;

  alif_update #(
    .THRESHOLD  (THRESHOLD),
    .ADAPT_STEP (ADAPT_STEP)
  ) u_update (
    .v       (lat_v),
    .a       (lat_a),
    .i_cur   (lat_i),
    .vm_leak (vm_leak),
    .ad_leak (ad_leak),
    .next_v  (upd_v),
    .next_a  (upd_a),
    .fire    (upd_fire)
  );

  // Input current registers, writable at any time; READ sees the pre-write value
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < N_NEURONS; n++) cur_mem[n] <= 8'h00;
    end else if (cfg_we) begin
      cur_mem[cfg_addr] <= cfg_data;
    end
  end

  // Sequencer: walk neurons through read/calc/write, detour through EMIT on a spike
  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      spk_valid <= 1'b0;
      lat_v     <= 8'h00;
      lat_a     <= 8'h00;
      lat_i     <= 8'h00;
      res_v     <= 8'h00;
      res_a     <= 8'h00;
      res_fire  <= 1'b0;
      for (int n = 0; n < N_NEURONS; n++) st_mem[n] <= '0;
`ifdef REFRACTORY_EN
      for (int n = 0; n < N_NEURONS; n++) refr[n] <= 8'h00;
`endif
    end else begin
      if (tick && busy) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (tick) begin
            busy  <= 1'b1;
            idx   <= '0;
            state <= ST_READ;
          end
        end
        ST_READ: begin
          lat_v <= st_mem[idx].v_mem;
          lat_a <= st_mem[idx].adapt;
`ifdef REFRACTORY_EN
          lat_i <= (refr[idx] != 8'h00) ? 8'h00 : cur_mem[idx];
`else
          lat_i <= cur_mem[idx];
`endif
          state <= ST_CALC;
        end
        ST_CALC: begin
          res_v    <= upd_v;
          res_a    <= upd_a;
          res_fire <= upd_fire;
          state    <= ST_WRITE;
        end
        ST_WRITE: begin
          st_mem[idx].v_mem <= res_v;
          st_mem[idx].adapt <= res_a;
`ifdef REFRACTORY_EN
          if (res_fire) refr[idx] <= REFRACT_LOAD;
          else if (refr[idx] != 8'h00) refr[idx] <= refr[idx] - 8'd1;
`endif
          if (res_fire) begin
            spk_valid <= 1'b1;
            state     <= ST_EMIT;
          end else if (idx == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            idx   <= idx + 1'b1;
            state <= ST_READ;
          end
        end
        ST_EMIT: begin
          if (spk_ready) begin
            spk_valid <= 1'b0;
            if (idx == LAST) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_READ;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
